// File: rtl/burst_reduce_memory.sv
// burst_reduce_memory
// Memory-stage extension that executes a multi-beat load-reduce instruction.
// It fetches `count` words starting at `base_addr`, stepping by a signed byte
// `stride`, and folds them with sum / xor / unsigned max / unsigned min. The
// result goes to register `rd`. The core is stalled through `busy` while beats
// are outstanding.
//
// Ports
//   CLK, nRST         clock, asynchronous active-low reset
//   start, mode, base_addr, stride, count, rd_in
//                     burst instruction from the execute stage
//   flush             synchronous abort from the hazard unit
//   mem_ren, mem_wen, mem_addr, mem_load, mem_busy
//                     load port towards the data memory
//   busy              stall request to the core
//   exception, exc_cause
//                     illegal-operand report (01 bad count, 10 misaligned)
//   reg_w, reg_waddr, reg_wdata
//                     register-file write of the reduction result
module burst_reduce_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int CNT_W      = $clog2(MAX_BEATS) + 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [11:0]           stride,
    input  logic [CNT_W-1:0]      count,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_load,
    input  logic                  mem_busy,
    output logic                  busy,
    output logic                  exception,
    output logic [1:0]            exc_cause,
    output logic                  reg_w,
    output logic [4:0]            reg_waddr,
    output logic [DATA_WIDTH-1:0] reg_wdata
);

    // Number of low address bits that must be zero for word alignment.
    localparam int AL_W = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [1:0] M_SUM = 2'b00;
    localparam logic [1:0] M_XOR = 2'b01;
    localparam logic [1:0] M_MAX = 2'b10;
    localparam logic [1:0] M_MIN = 2'b11;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [1:0]            mode_q, mode_d;
    logic [4:0]            rd_q, rd_d;

    logic                  bad_count_s;
    logic                  misaligned_s;
    logic                  legal_s;
    logic                  accept_s;
    logic [ADDR_WIDTH-1:0] stride_ext_s;

    // One reduction step; max/min are unsigned compares, sum wraps.
    function automatic logic [DATA_WIDTH-1:0] reduce_op(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] beat
    );
        case (op)
            M_SUM:   return acc + beat;
            M_XOR:   return acc ^ beat;
            M_MAX:   return (beat > acc) ? beat : acc;
            M_MIN:   return (beat < acc) ? beat : acc;
            default: return acc;
        endcase
    endfunction

    // Identity element of each operator so the first beat lands unchanged.
    function automatic logic [DATA_WIDTH-1:0] acc_init(input logic [1:0] op);
        case (op)
            M_MIN:   return {DATA_WIDTH{1'b1}};
            default: return {DATA_WIDTH{1'b0}};
        endcase
    endfunction

    assign stride_ext_s = {{(ADDR_WIDTH-12){stride[11]}}, stride};
    assign bad_count_s  = (count == {CNT_W{1'b0}}) || (count > CNT_W'(MAX_BEATS));
    assign misaligned_s = (base_addr[AL_W-1:0] != {AL_W{1'b0}}) ||
                          (stride_ext_s[AL_W-1:0] != {AL_W{1'b0}});
    assign legal_s      = !bad_count_s && !misaligned_s;
    // A flush cancels the instruction, so it also suppresses its exception.
    assign accept_s     = (state_q == S_IDLE) && start && !flush;

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && legal_s) begin
                    state_d  = S_LOAD;
                    acc_d    = acc_init(mode);
                    addr_d   = base_addr;
                    stride_d = stride_ext_s;
                    rem_d    = count;
                    mode_d   = mode;
                    rd_d     = rd_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!mem_busy) begin
                    acc_d  = reduce_op(mode_q, acc_q, mem_load);
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            acc_q    <= {DATA_WIDTH{1'b0}};
            addr_q   <= {ADDR_WIDTH{1'b0}};
            stride_q <= {ADDR_WIDTH{1'b0}};
            rem_q    <= {CNT_W{1'b0}};
            mode_q   <= 2'b00;
            rd_q     <= 5'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            rd_q     <= rd_d;
        end
    end

    // Outputs are gated by state so they fall to zero as soon as reset hits.
    assign mem_ren   = (state_q == S_LOAD);
    assign mem_wen   = 1'b0;
    assign mem_addr  = mem_ren ? addr_q : {ADDR_WIDTH{1'b0}};
    assign busy      = (accept_s && legal_s) || (state_q == S_LOAD);
    assign exception = accept_s && !legal_s;
    assign exc_cause = !exception ? 2'b00 : (bad_count_s ? 2'b01 : 2'b10);
    assign reg_w     = (state_q == S_WB) && !flush;
    assign reg_waddr = reg_w ? rd_q : 5'd0;
    assign reg_wdata = reg_w ? acc_q : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_burst_reduce_memory.sv
module tb_burst_reduce_memory;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr;
    logic [11:0] stride;
    logic [4:0]  count;
    logic [4:0]  rd_in;
    logic        flush;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_load;
    logic        mem_busy;
    logic        busy;
    logic        exception;
    logic [1:0]  exc_cause;
    logic        reg_w;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    logic [31:0] addr_exp_q [$];
    logic [36:0] res_exp_q [$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_a = 32'd0;

    burst_reduce_memory dut (
        .CLK(CLK), .nRST(nRST), .start(start), .mode(mode),
        .base_addr(base_addr), .stride(stride), .count(count), .rd_in(rd_in),
        .flush(flush), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_load(mem_load), .mem_busy(mem_busy), .busy(busy),
        .exception(exception), .exc_cause(exc_cause), .reg_w(reg_w),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
    );

    always #5 CLK = ~CLK;

    assign mem_load = mem[mem_addr[9:2]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] b, input logic [11:0] s, input int i);
        int sv;
        sv = int'(signed'(s));
        return b + 32'(i * sv);
    endfunction

    // Reference: gather all words the burst touches, then fold them.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] b,
                                          input logic [11:0] s, input int n);
        logic [31:0] vals [$];
        logic [31:0] r;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = beat_addr(b, s, i);
            vals.push_back(mem[a[9:2]]);
        end
        r = (m == 2'b11) ? 32'hFFFF_FFFF : 32'd0;
        foreach (vals[i]) begin
            case (m)
                2'b00:   r = r + vals[i];
                2'b01:   r = r ^ vals[i];
                2'b10:   if (vals[i] > r) r = vals[i];
                default: if (vals[i] < r) r = vals[i];
            endcase
        end
        return r;
    endfunction

    task automatic push_addrs(input logic [31:0] b, input logic [11:0] s, input int n);
        for (int i = 0; i < n; i++) addr_exp_q.push_back(beat_addr(b, s, i));
    endtask

    // Monitor: compares every accepted beat address and every register write.
    always @(negedge CLK) begin
        if (!nRST) begin
            hold_v <= 1'b0;
        end else begin
            chk("mem_wen", mem_wen, 1'b0);
            if (hold_v && mem_ren) chk("addr_hold", mem_addr, hold_a);
            if (mem_ren && !mem_busy && !flush) begin
                if (addr_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL beat_addr: unexpected beat at %0h", mem_addr);
                end else begin
                    chk("beat_addr", mem_addr, addr_exp_q.pop_front());
                end
            end
            hold_v <= mem_ren && mem_busy;
            hold_a <= mem_addr;
            if (reg_w) begin
                if (res_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL result: unexpected reg_w rd=%0d data=%0h", reg_waddr, reg_wdata);
                end else begin
                    chk("result", {reg_waddr, reg_wdata}, res_exp_q.pop_front());
                end
            end
        end
    end

    // Issue one legal burst, called at posedge+1 in IDLE; returns at posedge+1 in IDLE.
    task automatic do_burst(input logic [1:0] m, input logic [31:0] b, input logic [11:0] s,
                            input int n, input logic [4:0] rd, input int wmode, input bit glitch);
        int k;
        int waits;
        int beats;
        push_addrs(b, s, n);
        res_exp_q.push_back({rd, model(m, b, s, n)});
        start = 1'b1; mode = m; base_addr = b; stride = s; count = 5'(n); rd_in = rd;
        mem_busy = 1'b0;
        @(negedge CLK);
        chk("start_busy", busy, 1'b1);
        chk("start_exc", exception, 1'b0);
        @(posedge CLK); #1;
        start = 1'b0;
        k = 0; waits = 0; beats = 0;
        forever begin
            case (wmode)
                1:       mem_busy = ($urandom_range(0, 99) < 30);
                2:       mem_busy = (beats == 1 && waits < 2);
                default: mem_busy = 1'b0;
            endcase
            if (glitch) begin
                start = 1'($urandom_range(0, 1));
                mode  = 2'($urandom_range(0, 3));
            end
            @(negedge CLK);
            if (reg_w) break;
            chk("load_busy", busy, 1'b1);
            if (mem_ren && mem_busy) waits++;
            else if (mem_ren) beats++;
            k++;
            if (k > 300) begin
                checks++; failures++;
                $display("FAIL timeout: no reg_w after %0d cycles", k);
                break;
            end
            @(posedge CLK); #1;
        end
        chk("wb_busy", busy, 1'b0);
        chk("latency", k, n + waits);
        @(posedge CLK); #1;
        start = 1'b0; mem_busy = 1'b0;
    endtask

    // Illegal operands: single-cycle exception, no memory access.
    task automatic exc_case(input logic [31:0] b, input logic [11:0] s, input int n,
                            input logic [1:0] cause);
        start = 1'b1; mode = 2'b00; base_addr = b; stride = s; count = 5'(n); rd_in = 5'd3;
        @(negedge CLK);
        chk("exc", exception, 1'b1);
        chk("exc_cause", exc_cause, cause);
        chk("exc_busy", busy, 1'b0);
        chk("exc_ren", mem_ren, 1'b0);
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        chk("exc_pulse", exception, 1'b0);
        chk("exc_ren2", mem_ren, 1'b0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; start = 1'b0; mode = 2'b00; base_addr = 32'd0; stride = 12'd0;
        count = 5'd0; rd_in = 5'd0; flush = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h40] = 32'd1; mem[8'h41] = 32'd2; mem[8'h42] = 32'd3; mem[8'h43] = 32'hFFFF_FFFF;
        mem[8'h84] = 32'd7; mem[8'h82] = 32'h8000_0000; mem[8'h80] = 32'd3;

        #3;
        chk("rst_ren", mem_ren, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_exc", {exception, exc_cause}, 3'd0);
        chk("rst_regw", {reg_w, reg_waddr, reg_wdata}, 38'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Sum with wrap, zero wait states.
        do_burst(2'b00, 32'h100, 12'd4, 4, 5'd5, 0, 1'b0);
        chk("sum_model", model(2'b00, 32'h100, 12'd4, 4), 32'd5);
        // Max / min with stride -8 and two waits on beat 2.
        do_burst(2'b10, 32'h210, 12'hFF8, 3, 5'd6, 2, 1'b0);
        do_burst(2'b11, 32'h210, 12'hFF8, 3, 5'd7, 2, 1'b0);
        // Address wrap; rd 0 still pulses reg_w.
        do_burst(2'b01, 32'hFFFF_FFF8, 12'd4, 4, 5'd0, 0, 1'b0);
        // Largest legal burst.
        do_burst(2'b00, 32'h40, 12'd4, 16, 5'd9, 0, 1'b0);

        exc_case(32'h100, 12'd4, 0, 2'b01);
        exc_case(32'h100, 12'd4, 17, 2'b01);
        exc_case(32'h102, 12'd4, 4, 2'b10);
        exc_case(32'h102, 12'd4, 0, 2'b01);
        exc_case(32'h100, 12'd6, 4, 2'b10);

        // Flush after two accepted beats.
        push_addrs(32'h300, 12'd4, 2);
        start = 1'b1; mode = 2'b00; base_addr = 32'h300; stride = 12'd4; count = 5'd4; rd_in = 5'd8;
        @(posedge CLK); #1; start = 1'b0;
        @(negedge CLK); @(posedge CLK); #1;
        @(negedge CLK); @(posedge CLK); #1;
        flush = 1'b1;
        @(negedge CLK);
        chk("flush_regw", reg_w, 1'b0);
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        chk("flush_ren", mem_ren, 1'b0);
        chk("flush_busy", busy, 1'b0);
        chk("flush_regw2", reg_w, 1'b0);
        @(posedge CLK); #1;
        do_burst(2'b11, 32'h100, 12'd4, 4, 5'd10, 0, 1'b0);

        // Asynchronous reset between edges during LOAD.
        push_addrs(32'h200, 12'd4, 2);
        start = 1'b1; mode = 2'b00; base_addr = 32'h200; stride = 12'd4; count = 5'd8; rd_in = 5'd11;
        @(posedge CLK); #1; start = 1'b0;
        @(negedge CLK); @(posedge CLK); #1;
        @(negedge CLK); @(posedge CLK); #3;
        nRST = 1'b0;
        #1;
        chk("arst_ren", mem_ren, 1'b0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_regw", {reg_w, reg_waddr, reg_wdata}, 38'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Random bursts with wait states and start toggling during LOAD.
        for (int t = 0; t < 30; t++) begin
            do_burst(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                     12'(($urandom_range(0, 1023) - 512) * 4), $urandom_range(1, 16),
                     5'($urandom_range(0, 31)), 1, 1'($urandom_range(0, 1)));
        end

        @(posedge CLK); #1;
        @(negedge CLK);
        chk("addr_q_empty", addr_exp_q.size(), 0);
        chk("res_q_empty", res_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_reduce_memory.md
# burst_reduce_memory

Memory-stage RISC-MGMT extension executing a custom multi-beat load-reduce instruction. It fetches `count` words from `base_addr` at a byte `stride`, reduces them with a selected operator (sum, xor, unsigned max, unsigned min), and writes the result to `rd`. It sits between the execute-to-memory extension register and the core's memory-stage RISC-MGMT port. It stalls the pipeline via `busy` for the duration of the burst.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; memory beat width.
- `ADDR_WIDTH`, 32: byte address width.
- `MAX_BEATS`, 16: largest legal `count`; power of two ≥ 2.
- `CNT_W`, `$clog2(MAX_BEATS)+1`: derived width of `count`.

Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `start`  in  1  execute stage presents a valid burst instruction this cycle.
- `mode`  in  2  00 sum, 01 xor, 10 max unsigned, 11 min unsigned.
- `base_addr`  in  ADDR_WIDTH  first beat byte address.
- `stride`  in  12  signed byte stride, sign-extended to ADDR_WIDTH.
- `count`  in  CNT_W  number of beats.
- `rd_in`  in  5  destination register.
- `flush`  in  1  synchronous abort from hazard unit.
- `mem_ren`  out  1  load request.
- `mem_wen`  out  1  constant 0.
- `mem_addr`  out  ADDR_WIDTH  load address.
- `mem_load`  in  DATA_WIDTH  load data, valid when `mem_ren` & !`mem_busy`.
- `mem_busy`  in  1  memory wait.
- `busy`  out  1  stall request to core.
- `exception`  out  1  illegal-operand exception.
- `exc_cause`  out  2  01 bad count, 10 misaligned, 00 none.
- `reg_w`  out  1  register write enable.
- `reg_waddr`  out  5  write address.
- `reg_wdata`  out  DATA_WIDTH  reduction result.

## Operation
- FSM states: IDLE, LOAD, WB.
- IDLE, `start`=1: operands are checked combinationally in the same cycle.
  - `count`==0 or `count`>MAX_BEATS gives `exception`=1, `exc_cause`=01.
  - Otherwise, `base_addr` or `stride` not a multiple of DATA_WIDTH/8 gives `exception`=1, `exc_cause`=10.
  - Bad count takes priority over misalignment.
  - On exception: stay IDLE, no memory access, `busy`=0.
  - Legal operands: latch mode, stride, rd, `count`, address=`base_addr`; init accumulator; assert `busy`; go to LOAD.
- Accumulator init values: sum/xor/max = 0; min = all ones.
- LOAD: `mem_ren`=1, `mem_addr`=current address.
  - Each cycle with `mem_busy`=0 is an accepted beat: accumulator ← op(acc, `mem_load`); address ← address + stride (wraps modulo 2^ADDR_WIDTH); remaining ← remaining − 1.
  - Accepting the last beat moves to WB.
- Sum wraps modulo 2^DATA_WIDTH.
- Max/min compare unsigned.
- WB: `reg_w`=1, `reg_waddr`=latched rd, `reg_wdata`=accumulator, `busy`=0; go to IDLE next cycle.
- `rd_in`==0: the burst still executes; `reg_w` is still pulsed, and the core discards the write to x0.
- `start` while in LOAD or WB is ignored. The core holds execute while `busy`.
- `flush`=1 in any state: next state IDLE, accumulator discarded, no `reg_w`. `flush` wins over `start` in IDLE.
- `mem_wen` is always 0.

## Timing
- Reset values (nRST low, asynchronous): state IDLE, accumulator 0, address 0, remaining 0. All outputs are 0: `mem_ren`, `mem_addr`, `busy`, `exception`, `exc_cause`, `reg_w`, `reg_waddr`, `reg_wdata`.
- `busy` = (IDLE & `start` & legal & !`flush`) | LOAD. It is combinational in the start cycle.
- `exception` and `exc_cause` are combinational, one cycle, only in IDLE with `start`.
- With zero wait states, latency from `start` to `reg_w` is `count`+1 cycles: start cycle T, beats at T+1..T+count, WB at T+count+1.
- Each wait cycle (`mem_busy`=1) adds one cycle. `mem_addr` and `mem_ren` are held stable while `mem_busy`=1.
- A new `start` is accepted on the cycle after WB at the earliest.
- Reset mid-burst: immediate IDLE, `mem_ren` drops asynchronously, no `reg_w`.

## Test plan
- Sum, zero wait: base 0x100, stride 4, count 4, memory {1,2,3,0xFFFFFFFF}, rd 5. Expect addresses 0x100/104/108/10C, `reg_wdata`=5 (wrapped), `reg_w` at T+5, `busy` high T..T+4.
- Max/min with waits: stride −8, count 3, data {7,0x80000000,3}, `mem_busy` two cycles on beat 2. Expect max 0x80000000 and min 3, `mem_addr` held during the waits, latency 6.
- Exceptions: count 0 gives cause 01; count 17 gives cause 01; base 0x102 gives cause 10; count 0 with base 0x102 gives cause 01. Each is a single-cycle pulse with no `mem_ren`.
- Address wrap: base 0xFFFFFFF8, stride 4, count 4. Expect addresses FFFFFFF8, FFFFFFFC, 0, 4.
- Flush in LOAD after 2 beats: next cycle IDLE, `mem_ren`=0, no `reg_w`. A following burst gives the correct fresh result (accumulator re-initialised).
- Async reset asserted mid-LOAD between clock edges: all outputs 0 immediately. `start` ignored while `start` overlaps an active LOAD.
